mmio_wr_demux: RTL and testbench

Write-side counterpart of the 6-way, 3-bit-select read multiplexer in the OTTER multicycle datapath. Routes one CPU store, selected by a 3-bit channel index, into one of six held 32-bit output registers with byte enables. Gives per-channel update strobes, a registered readback port and error flagging for unused select codes. Sits between the memory/IO store path and the peripheral output latches.

---
 rtl/mmio_wr_demux.sv | 140 ++++++++++++++
 tb/tb_mmio_wr_demux.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mmio_wr_demux.sv
// Six-channel store demultiplexer: routes one byte-masked CPU write into held
// channel registers, with per-channel strobes, registered readback and select-error flags.

module mmio_wr_chan #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     q_o,
  output logic                  strobe_o
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] q_q, q_d;
  logic              stb_q;

  // Disabled bytes keep their value; a write with no byte enables still strobes.
  always_comb begin
    q_d = q_q;
    if (wr_en_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) q_d[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q   <= RST_VAL;
      stb_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      stb_q <= wr_en_i;
    end
  end

  assign q_o      = q_q;
  assign strobe_o = stb_q;
endmodule

module mmio_wr_demux #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [2:0]            sel_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic                  re_i,
  input  logic                  clr_err_i,
  output logic [DATA_W-1:0]     o0_o,
  output logic [DATA_W-1:0]     o1_o,
  output logic [DATA_W-1:0]     o2_o,
  output logic [DATA_W-1:0]     o3_o,
  output logic [DATA_W-1:0]     o4_o,
  output logic [DATA_W-1:0]     o5_o,
  output logic [5:0]            strobe_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  rvalid_o,
  output logic                  err_o,
  output logic                  err_sticky_o
);
  localparam int NUM_CH = 6;

  logic [NUM_CH-1:0]             wr_hit;
  logic [NUM_CH-1:0][DATA_W-1:0] chan_q;
  logic [NUM_CH-1:0]             chan_stb;
  logic                          sel_ok;

  assign sel_ok = (sel_i < 3'd6);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_hit[g] = we_i && (sel_i == 3'(g));
    mmio_wr_chan #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_chan (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .wr_en_i  (wr_hit[g]),
      .be_i     (be_i),
      .wdata_i  (wdata_i),
      .q_o      (chan_q[g]),
      .strobe_o (chan_stb[g])
    );
  end

  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic              sticky_q, sticky_d;

  // Readback sees pre-edge channel contents, so a same-cycle write is read-before-write.
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_i == 3'(c)) rd_word = chan_q[c];
    end
  end

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = re_i;
    err_d    = (we_i || re_i) && !sel_ok;
    sticky_d = sticky_q;
    if (re_i) rdata_d = sel_ok ? rd_word : '0;
    if (err_d)          sticky_d = 1'b1;
    else if (clr_err_i) sticky_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign o0_o         = chan_q[0];
  assign o1_o         = chan_q[1];
  assign o2_o         = chan_q[2];
  assign o3_o         = chan_q[3];
  assign o4_o         = chan_q[4];
  assign o5_o         = chan_q[5];
  assign strobe_o     = chan_stb;
  assign rdata_o      = rdata_q;
  assign rvalid_o     = rvalid_q;
  assign err_o        = err_q;
  assign err_sticky_o = sticky_q;
endmodule

// File: tb/tb_mmio_wr_demux.sv
// Directed + random bench for mmio_wr_demux: an array-of-registers model checked
// against the DUT every cycle, plus hand-computed literal pins from the test plan.

module tb_mmio_wr_demux;
  logic        clk = 1'b0;
  logic        rst, we, re, clr;
  logic [2:0]  sel;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] o0, o1, o2, o3, o4, o5, rdata;
  logic [5:0]  strobe;
  logic        rvalid, err, sticky;
  wire  [31:0] dut_o [6];

  assign dut_o[0] = o0;
  assign dut_o[1] = o1;
  assign dut_o[2] = o2;
  assign dut_o[3] = o3;
  assign dut_o[4] = o4;
  assign dut_o[5] = o5;

  always #5 clk = ~clk;

  mmio_wr_demux #(.DATA_W(32), .RST_VAL(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .we_i(we), .sel_i(sel), .wdata_i(wdata), .be_i(be),
    .re_i(re), .clr_err_i(clr),
    .o0_o(o0), .o1_o(o1), .o2_o(o2), .o3_o(o3), .o4_o(o4), .o5_o(o5),
    .strobe_o(strobe), .rdata_o(rdata), .rvalid_o(rvalid), .err_o(err), .err_sticky_o(sticky)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: six plain registers plus expected pulse outputs.
  logic [31:0] m_reg [6];
  logic [5:0]  m_strobe;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_err, m_sticky;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic w, input logic rd, input logic [2:0] s,
                            input logic [31:0] d, input logic [3:0] b, input logic c);
    bit bad;
    if (r) begin
      for (int i = 0; i < 6; i++) m_reg[i] = 32'h0;
      m_strobe = '0; m_rdata = '0; m_rvalid = 1'b0; m_err = 1'b0; m_sticky = 1'b0;
      return;
    end
    bad      = (s > 3'd5);
    m_strobe = '0;
    m_rvalid = rd;
    m_err    = (w || rd) && bad;
    if (rd) m_rdata = bad ? 32'h0 : m_reg[s];
    if (w && !bad) begin
      for (int k = 0; k < 4; k++)
        if (b[k]) m_reg[s][8*k +: 8] = d[8*k +: 8];
      m_strobe[s] = 1'b1;
    end
    if (m_err) m_sticky = 1'b1;
    else if (c) m_sticky = 1'b0;
  endtask

  task automatic step(input logic r, input logic w, input logic rd, input logic [2:0] s,
                      input logic [31:0] d, input logic [3:0] b, input logic c);
    rst = r; we = w; re = rd; sel = s; wdata = d; be = b; clr = c;
    @(posedge clk);
    model_step(r, w, rd, s, d, b, c);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b0);
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 6; i++) check($sformatf("O%0d", i), dut_o[i], m_reg[i]);
      check("STROBE", {26'h0, strobe}, {26'h0, m_strobe});
      check("RDATA", rdata, m_rdata);
      check("RVALID", {31'h0, rvalid}, {31'h0, m_rvalid});
      check("ERR", {31'h0, err}, {31'h0, m_err});
      check("ERR_STICKY", {31'h0, sticky}, {31'h0, m_sticky});
    end
  end

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; sel = 3'd0; wdata = 32'h0; be = 4'h0; clr = 1'b0;
    step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b0);
    chk_en = 1'b1;
    check("reset O2", o2, 32'h0);
    check("reset RVALID/ERR/STICKY", {29'h0, rvalid, err, sticky}, 32'h0);

    // Full write then partial write to channel 2.
    step(1'b0, 1'b1, 1'b0, 3'd2, 32'hDEADBEEF, 4'hF, 1'b0);
    check("full wr O2", o2, 32'hDEADBEEF);
    check("full wr STROBE", {26'h0, strobe}, 32'h4);
    check("full wr O0", o0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 3'd2, 32'h11223344, 4'b0101, 1'b0);
    check("partial wr O2", o2, 32'hDE22BE44);
    check("2nd strobe cycle", {26'h0, strobe}, 32'h4);

    // Read-before-write on the same channel.
    step(1'b0, 1'b1, 1'b1, 3'd2, 32'h0, 4'hF, 1'b0);
    check("rbw RDATA", rdata, 32'hDE22BE44);
    check("rbw RVALID", {31'h0, rvalid}, 32'h1);
    check("rbw O2", o2, 32'h0);
    idle();
    check("idle STROBE", {26'h0, strobe}, 32'h0);
    check("RDATA held", rdata, 32'hDE22BE44);

    // Invalid selects and sticky error handling.
    step(1'b0, 1'b1, 1'b0, 3'd7, 32'hFFFFFFFF, 4'hF, 1'b0);
    check("bad wr ERR", {31'h0, err}, 32'h1);
    check("bad wr STICKY", {31'h0, sticky}, 32'h1);
    check("bad wr STROBE", {26'h0, strobe}, 32'h0);
    step(1'b0, 1'b0, 1'b1, 3'd6, 32'h0, 4'h0, 1'b1);
    check("set-wins STICKY", {31'h0, sticky}, 32'h1);
    check("bad rd RDATA", rdata, 32'h0);
    check("bad rd RVALID", {31'h0, rvalid}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b1);
    check("clr STICKY", {31'h0, sticky}, 32'h0);
    check("clr ERR", {31'h0, err}, 32'h0);

    // Walking strobe across all channels.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0, 3'(i), 32'(i + 1), 4'hF, 1'b0);
      check($sformatf("walk STROBE %0d", i), {26'h0, strobe}, 32'(1 << i));
    end
    check("walk O3", o3, 32'h4);
    check("walk O5", o5, 32'h6);
    // Back-to-back reads keep RVALID high.
    step(1'b0, 1'b0, 1'b1, 3'd4, 32'h0, 4'h0, 1'b0);
    check("rd O4", rdata, 32'h5);
    step(1'b0, 1'b0, 1'b1, 3'd1, 32'h0, 4'h0, 1'b0);
    check("rd O1", rdata, 32'h2);
    check("b2b RVALID", {31'h0, rvalid}, 32'h1);
    // Reset during a write discards it.
    step(1'b1, 1'b1, 1'b0, 3'd1, 32'hCAFEF00D, 4'hF, 1'b0);
    check("rst-wr O1", o1, 32'h0);
    check("rst O5", o5, 32'h0);
    check("rst STROBE", {26'h0, strobe}, 32'h0);

    // Random stream against the model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
           $urandom, 4'($urandom), ($urandom_range(0, 7) == 0));
    end
    idle();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
